// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: HLT opcode, default NOP word and FSM state encodings.
package fetch_stage_pkg;

  localparam logic [3:0]  OP_HLT        = 4'b1111;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: instruction, its PC and a valid bit.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [15:0] next_instr,
  input  logic [15:0] next_pc,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic        valid
);

  // flush wins over hold so a redirect always kills the wrong-path instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc    <= 16'h0000;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr <= next_instr;
      pc    <= next_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a variable-latency handshake and fills IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/flush performance counters.
//
// state   | meaning
// FETCH   | request outstanding at fetch_addr
// HOLD    | response captured in hold buffer while stalled, no request
// DISCARD | redirected with a request in flight; wait for and drop its data
// HALT    | HLT fetched, no requests until a redirect
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  fetch_state_t state, state_nxt;
  logic [15:0]  pc, pc_nxt;
  logic [15:0]  fetch_addr, fetch_addr_nxt;
  logic [15:0]  hold_buf, hold_buf_nxt;
  logic [15:0]  load_instr;
  logic [15:0]  seq_pc;
  logic         ifid_load;

  assign seq_pc    = fetch_addr + 16'd2;
  assign imem_addr = fetch_addr;
  assign imem_req  = rst_n && ((state == ST_FETCH) || (state == ST_DISCARD));
  assign halted    = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      hold_buf   <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fetch_addr <= fetch_addr_nxt;
      hold_buf   <= hold_buf_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    hold_buf_nxt   = hold_buf;
    ifid_load      = 1'b0;
    load_instr     = imem_rdata;

    if (redirect) begin
      pc_nxt       = redirect_pc;
      hold_buf_nxt = NOP_INSTR;
      // an unanswered request keeps the bus at the old address until it completes
      if (((state == ST_FETCH) || (state == ST_DISCARD)) && !imem_valid) begin
        state_nxt = ST_DISCARD;
      end else begin
        state_nxt      = ST_FETCH;
        fetch_addr_nxt = redirect_pc;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_valid) begin
            if (stall) begin
              hold_buf_nxt = imem_rdata;
              state_nxt    = ST_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_load  = 1'b1;
            load_instr = hold_buf;
          end
        end
        ST_DISCARD: begin
          if (imem_valid) begin
            fetch_addr_nxt = pc;
            state_nxt      = ST_FETCH;
          end
        end
        default: ;
      endcase

      if (ifid_load) begin
        if (is_hlt(load_instr)) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt      = ST_FETCH;
          pc_nxt         = seq_pc;
          fetch_addr_nxt = seq_pc;
        end
      end
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifid_load),
    .hold      (stall),
    .flush     (redirect),
    .next_instr(load_instr),
    .next_pc   (fetch_addr),
    .instr     (ifid_instr),
    .pc        (ifid_pc),
    .valid     (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 16'h0000;
      perf_flush_cnt <= 16'h0000;
    end else begin
      if (ifid_load && !redirect && (perf_fetch_cnt != 16'hFFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (redirect && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory responder with random latency feeds a
// scoreboard of expected IF/ID loads; a negedge monitor pops and compares.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0000;
  localparam int          N_CYCLES = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  entry_t      sb_q[$];
  logic [15:0] mem [32768];
  logic [15:0] path_pc;
  logic [15:0] req_addr;
  bit          started, exp_halted, exp_flush, due, busy, taint;
  int          lat, halt_wait;
  int          errors = 0;
  int          checks = 0;

  logic        prev_valid;
  logic [15:0] prev_pc, prev_instr;
  bit          load_ev;
  entry_t      e;

  task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 16'hFFFC;
      1:       return 16'hFFFE;
      default: return r[15:0] & 16'hFFFE;
    endcase
  endfunction

  // monitor: one IF/ID load is expected exactly when a response is pending and released
  always @(negedge clk) begin
    if (started) begin
      if (!rst_n) begin
        check_eq("req_in_reset", {15'd0, imem_req}, 16'd0);
        check_eq("ifid_valid_reset", {15'd0, ifid_valid}, 16'd0);
        check_eq("ifid_instr_reset", ifid_instr, NOP);
        check_eq("ifid_pc_reset", ifid_pc, 16'h0000);
        check_eq("halted_reset", {15'd0, halted}, 16'd0);
        prev_valid = 1'b0;
      end else begin
        load_ev = ifid_valid && (!prev_valid || (ifid_pc != prev_pc) || (ifid_instr != prev_instr));
        if (exp_flush) begin
          check_eq("flush_valid", {15'd0, ifid_valid}, 16'd0);
          check_eq("flush_instr", ifid_instr, NOP);
          exp_flush = 1'b0;
        end
        check_eq("load_event", {15'd0, load_ev}, {15'd0, due});
        if (load_ev && (sb_q.size() != 0)) begin
          e = sb_q.pop_front();
          check_eq("ifid_pc", ifid_pc, e.pc);
          check_eq("ifid_instr", ifid_instr, e.instr);
          if (e.instr[15:12] == 4'hF) exp_halted = 1'b1;
        end
        check_eq("halted", {15'd0, halted}, {15'd0, exp_halted});
        if (exp_halted || (sb_q.size() != 0))
          check_eq("req_idle", {15'd0, imem_req}, 16'd0);
        prev_valid = ifid_valid;
      end
      prev_pc    = ifid_pc;
      prev_instr = ifid_instr;
      due        = 1'b0;
    end
  end

  initial begin
    bit do_rst, do_redir, zero_wait;
    logic [31:0] r;
    for (int i = 0; i < 32768; i++) begin
      r = $urandom;
      mem[i] = r[15:0];
    end
    path_pc = RESET_PC;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    started = 1'b1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      zero_wait = (cyc < 40);
      do_rst = !zero_wait &&
               (($urandom_range(0, 299) == 0) || (taint && ($urandom_range(0, 7) == 0)));
      if (do_rst) begin
        rst_n = 1'b0;
        redirect = 1'b0;
        stall = $urandom_range(0, 1);
        imem_valid = 1'b0;
        sb_q.delete();
        path_pc = RESET_PC;
        exp_halted = 1'b0;
        exp_flush = 1'b0;
        due = 1'b0;
        busy = 1'b0;
        taint = 1'b0;
        halt_wait = 0;
      end else begin
        rst_n = 1'b1;
        #1;
        stall = zero_wait ? 1'b0 : ($urandom_range(0, 3) == 0);
        do_redir = !zero_wait && (($urandom_range(0, 11) == 0) || (exp_halted && (halt_wait >= 3)));
        halt_wait = exp_halted ? halt_wait + 1 : 0;
        redirect = do_redir;
        if (do_redir) redirect_pc = pick_target();
        imem_valid = 1'b0;
        r = $urandom;
        imem_rdata = r[15:0];
        if (imem_req) begin
          if (!busy) begin
            busy = 1'b1;
            req_addr = imem_addr;
            lat = (zero_wait || ($urandom_range(0, 1) == 0)) ? 0 : $urandom_range(1, 3);
          end else begin
            check_eq("addr_stable", imem_addr, req_addr);
          end
          if (do_redir) taint = 1'b1;
          if (lat == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[imem_addr[15:1]];
            busy = 1'b0;
            if (!taint) begin
              check_eq("fetch_addr_path", imem_addr, path_pc);
              sb_q.push_back({imem_addr, imem_rdata});
              path_pc = imem_addr + 16'd2;
            end
            taint = 1'b0;
          end else begin
            lat--;
          end
        end
        if (do_redir) begin
          sb_q.delete();
          path_pc = redirect_pc;
          exp_halted = 1'b0;
          exp_flush = 1'b1;
          halt_wait = 0;
        end
        due = !do_redir && !stall && (sb_q.size() != 0);
      end
      @(negedge clk);
      #1;
    end

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
